// File: rtl/reservation_station.sv
// reservation_station: out-of-order ALU issue buffer.
// Holds issued instructions until both operands are available. Operands are
// captured from the ALU and load/store common data buses, and the lowest-index
// ready entry is dispatched each cycle as a registered bundle.
// Optional feature macro: RS_CDB_FORWARD_EN. When defined, the select stage also
// accepts operands broadcast on a CDB this cycle, so a woken entry dispatches
// at the same edge.
module reservation_station #(
    parameter int RS_SIZE  = 16,
    parameter int RS_IDX_W = 4
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        flush_in,
    input  logic        issue_valid,
    input  logic [5:0]  issue_opcode,
    input  logic        issue_q1_busy,
    input  logic        issue_q2_busy,
    input  logic [5:0]  issue_q1,
    input  logic [5:0]  issue_q2,
    input  logic [31:0] issue_v1,
    input  logic [31:0] issue_v2,
    input  logic [31:0] issue_imm,
    input  logic [31:0] issue_pc,
    input  logic [5:0]  issue_rob_index,
    output logic        rs_full,
    input  logic        alu_cdb_valid,
    input  logic [5:0]  alu_cdb_rob,
    input  logic [31:0] alu_cdb_val,
    input  logic        lsb_cdb_valid,
    input  logic [5:0]  lsb_cdb_rob,
    input  logic [31:0] lsb_cdb_val,
    output logic [5:0]  alu_opcode,
    output logic [31:0] alu_val1,
    output logic [31:0] alu_val2,
    output logic [31:0] alu_imm,
    output logic [31:0] alu_pc,
    output logic [5:0]  alu_rob_index
);

    // Entry state
    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [5:0]  opcode_q [RS_SIZE];
    logic [5:0]  opcode_d [RS_SIZE];
    logic        q1b_q [RS_SIZE];
    logic        q1b_d [RS_SIZE];
    logic        q2b_q [RS_SIZE];
    logic        q2b_d [RS_SIZE];
    logic [5:0]  q1_q [RS_SIZE];
    logic [5:0]  q1_d [RS_SIZE];
    logic [5:0]  q2_q [RS_SIZE];
    logic [5:0]  q2_d [RS_SIZE];
    logic [31:0] v1_q [RS_SIZE];
    logic [31:0] v1_d [RS_SIZE];
    logic [31:0] v2_q [RS_SIZE];
    logic [31:0] v2_d [RS_SIZE];
    logic [31:0] imm_q [RS_SIZE];
    logic [31:0] imm_d [RS_SIZE];
    logic [31:0] pc_q [RS_SIZE];
    logic [31:0] pc_d [RS_SIZE];
    logic [5:0]  rob_q [RS_SIZE];
    logic [5:0]  rob_d [RS_SIZE];

    // Dispatch registers
    logic [5:0]  alu_opcode_q, alu_opcode_d;
    logic [31:0] alu_val1_q, alu_val1_d;
    logic [31:0] alu_val2_q, alu_val2_d;
    logic [31:0] alu_imm_q, alu_imm_d;
    logic [31:0] alu_pc_q, alu_pc_d;
    logic [5:0]  alu_rob_q, alu_rob_d;

    // Operands after this cycle's CDB snoop: {still_pending, value}
    logic [32:0] w1 [RS_SIZE];
    logic [32:0] w2 [RS_SIZE];
    logic [RS_SIZE-1:0] cand;
    logic                free_found, sel_found;
    logic [RS_IDX_W-1:0] free_idx, sel_idx;

    // Snoop one operand against both buses; the ALU bus wins a double match.
    function automatic logic [32:0] wake(input logic pend, input logic [5:0] tag,
                                         input logic [31:0] val,
                                         input logic av, input logic [5:0] at,
                                         input logic [31:0] aval,
                                         input logic lv, input logic [5:0] lt,
                                         input logic [31:0] lval);
        if (pend && av && (at == tag))
            return {1'b0, aval};
        if (pend && lv && (lt == tag))
            return {1'b0, lval};
        return {pend, val};
    endfunction

    assign rs_full = &busy_q;

    // Wake-up, free-slot search and lowest-index ready select
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            w1[i] = wake(q1b_q[i], q1_q[i], v1_q[i], alu_cdb_valid, alu_cdb_rob, alu_cdb_val,
                         lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val);
            w2[i] = wake(q2b_q[i], q2_q[i], v2_q[i], alu_cdb_valid, alu_cdb_rob, alu_cdb_val,
                         lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val);
`ifdef RS_CDB_FORWARD_EN
            cand[i] = busy_q[i] && !w1[i][32] && !w2[i][32];
`else
            cand[i] = busy_q[i] && !q1b_q[i] && !q2b_q[i];
`endif
        end
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = i[RS_IDX_W-1:0];
            end
            if (cand[i]) begin
                sel_found = 1'b1;
                sel_idx   = i[RS_IDX_W-1:0];
            end
        end
    end

    // Next-state: stall hold, flush, then wake-up / dispatch / issue
    always_comb begin
        busy_d       = busy_q;
        opcode_d     = opcode_q;
        q1b_d        = q1b_q;
        q2b_d        = q2b_q;
        q1_d         = q1_q;
        q2_d         = q2_q;
        v1_d         = v1_q;
        v2_d         = v2_q;
        imm_d        = imm_q;
        pc_d         = pc_q;
        rob_d        = rob_q;
        alu_opcode_d = alu_opcode_q;
        alu_val1_d   = alu_val1_q;
        alu_val2_d   = alu_val2_q;
        alu_imm_d    = alu_imm_q;
        alu_pc_d     = alu_pc_q;
        alu_rob_d    = alu_rob_q;
        if (rdy_in) begin
            if (flush_in) begin
                busy_d       = '0;
                alu_opcode_d = '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy_q[i]) begin
                        {q1b_d[i], v1_d[i]} = w1[i];
                        {q2b_d[i], v2_d[i]} = w2[i];
                    end
                end
                alu_opcode_d = '0;
                if (sel_found) begin
                    busy_d[sel_idx] = 1'b0;
                    alu_opcode_d    = opcode_q[sel_idx];
                    alu_val1_d      = w1[sel_idx][31:0];
                    alu_val2_d      = w2[sel_idx][31:0];
                    alu_imm_d       = imm_q[sel_idx];
                    alu_pc_d        = pc_q[sel_idx];
                    alu_rob_d       = rob_q[sel_idx];
                end
                // Free slot comes from registered busy, so it never aliases the dispatched one.
                if (issue_valid && !rs_full && free_found) begin
                    busy_d[free_idx]   = 1'b1;
                    opcode_d[free_idx] = issue_opcode;
                    q1_d[free_idx]     = issue_q1;
                    q2_d[free_idx]     = issue_q2;
                    {q1b_d[free_idx], v1_d[free_idx]} =
                        wake(issue_q1_busy, issue_q1, issue_v1, alu_cdb_valid, alu_cdb_rob,
                             alu_cdb_val, lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val);
                    {q2b_d[free_idx], v2_d[free_idx]} =
                        wake(issue_q2_busy, issue_q2, issue_v2, alu_cdb_valid, alu_cdb_rob,
                             alu_cdb_val, lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val);
                    imm_d[free_idx]    = issue_imm;
                    pc_d[free_idx]     = issue_pc;
                    rob_d[free_idx]    = issue_rob_index;
                end
            end
        end
    end

    // Control and dispatch registers, cleared by reset
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_q       <= '0;
            alu_opcode_q <= '0;
            alu_val1_q   <= '0;
            alu_val2_q   <= '0;
            alu_imm_q    <= '0;
            alu_pc_q     <= '0;
            alu_rob_q    <= '0;
        end else begin
            busy_q       <= busy_d;
            alu_opcode_q <= alu_opcode_d;
            alu_val1_q   <= alu_val1_d;
            alu_val2_q   <= alu_val2_d;
            alu_imm_q    <= alu_imm_d;
            alu_pc_q     <= alu_pc_d;
            alu_rob_q    <= alu_rob_d;
        end
    end

    // Entry payload; only meaningful while busy, so no reset
    always_ff @(posedge clk_in) begin
        opcode_q <= opcode_d;
        q1b_q    <= q1b_d;
        q2b_q    <= q2b_d;
        q1_q     <= q1_d;
        q2_q     <= q2_d;
        v1_q     <= v1_d;
        v2_q     <= v2_d;
        imm_q    <= imm_d;
        pc_q     <= pc_d;
        rob_q    <= rob_d;
    end

    assign alu_opcode    = alu_opcode_q;
    assign alu_val1      = alu_val1_q;
    assign alu_val2      = alu_val2_q;
    assign alu_imm       = alu_imm_q;
    assign alu_pc        = alu_pc_q;
    assign alu_rob_index = alu_rob_q;

endmodule

// File: doc/reservation_station.md
# reservation_station

Out-of-order issue buffer for the ALU. Accepts decoded instructions from the issue stage, holds each one until both source operands are available, and captures operand values from the two common data buses (ALU and load/store). Each cycle it dispatches the oldest-slot ready entry to `arithmetic_logic_unit` as a registered opcode/operand bundle. Opcode 0 on the dispatch port means no instruction is dispatched.

## Interface

Parameters:
- `RS_SIZE`, 16, number of entries (power of two, 2..32)
- `RS_IDX_W`, 4, log2(RS_SIZE)

Ports (all outputs registered unless noted):
- `clk_in`  in  1  clock, rising edge
- `rst_n_in`  in  1  reset; asynchronous assert, active-low
- `rdy_in`  in  1  global ready; low freezes all state
- `flush_in`  in  1  branch mispredict, clears all entries
- `issue_valid`  in  1  issue request this cycle
- `issue_opcode`  in  6  internal opcode, nonzero
- `issue_q1_busy`, `issue_q2_busy`  in  1  operand pending on a ROB tag
- `issue_q1`, `issue_q2`  in  6  producing ROB index
- `issue_v1`, `issue_v2`  in  32  operand value; valid when the matching busy bit is low
- `issue_imm`, `issue_pc`  in  32  immediate, instruction PC
- `issue_rob_index`  in  6  destination ROB index
- `rs_full`  out  1  combinational; no free entry
- `alu_cdb_valid`, `lsb_cdb_valid`  in  1  broadcast valid
- `alu_cdb_rob`, `lsb_cdb_rob`  in  6  broadcast ROB tag
- `alu_cdb_val`, `lsb_cdb_val`  in  32  broadcast value
- `alu_opcode`  out  6  dispatched opcode; 0 = idle
- `alu_val1`, `alu_val2`, `alu_imm`, `alu_pc`  out  32  dispatched operands
- `alu_rob_index`  out  6  dispatched ROB index

## Operation

- Per-entry state: `busy`, `opcode`, `q1_busy`/`q1`/`v1`, `q2_busy`/`q2`/`v2`, `imm`, `pc`, `rob`.
- Issue:
  - Accepted when `issue_valid && !rs_full`.
  - The instruction is written to the lowest-index free entry.
  - Each pending operand is also compared against both CDBs in the same cycle. On a match it is stored as ready with the CDB value.
  - `issue_valid` while `rs_full` is high is a protocol violation. The request is ignored and state does not change.
- Wake-up:
  - For every busy entry with `qN_busy` and a valid CDB whose tag equals `qN`, store the value and clear `qN_busy`.
  - If both CDBs match the same tag, the ALU bus wins.
- Select:
  - Candidate entries are those with `busy && !q1_busy && !q2_busy`, evaluated on registered state.
  - The lowest-index candidate is dispatched: its fields are registered onto the `alu_*` outputs and its `busy` is cleared.
  - If there is no candidate, `alu_opcode` is set to 0 and the other `alu_*` outputs hold their previous values.
- Simultaneous issue and dispatch are allowed in one cycle. A freed entry becomes reusable from the next cycle.
- `rs_full` is computed from registered `busy` bits only. A dispatch in the same cycle does not lower it.
- `flush_in`:
  - Synchronous; highest priority.
  - Clears all `busy` bits and sets `alu_opcode` to 0.
  - Any issue or dispatch in that cycle is discarded.
- `rdy_in` low:
  - No state changes and outputs hold.
  - CDB and issue inputs are ignored, because upstream is stalled too.
- Priority order: reset, then `!rdy_in`, then flush, then normal operation.

## Timing

- Reset (async, `rst_n_in` low) sets:
  - all `busy` = 0, so `rs_full` = 0;
  - `alu_opcode` = 0;
  - `alu_val1`, `alu_val2`, `alu_imm`, `alu_pc` = 0;
  - `alu_rob_index` = 0.
- Reset may assert mid-operation. All entries are lost and there is no partial state.
- Issue with both operands ready: written at edge N, dispatched at edge N+1. `alu_*` is valid during cycle N+1 to N+2 (1-cycle residency).
- Operand woken by a CDB at edge N: the entry is dispatchable at edge N+1 at the earliest (without `RS_CDB_FORWARD_EN`).
- At most one dispatch per cycle. `alu_opcode` is nonzero for exactly one cycle per dispatched instruction.
- The ALU is combinational. Its result is valid in the same cycle the `alu_*` outputs are valid.

## Configuration

- `RS_CDB_FORWARD_EN` defined:
  - The select stage also treats an entry as ready when each pending operand matches a valid CDB tag this cycle.
  - That entry dispatches at the same edge, using the CDB value (ALU bus wins on a double match).
  - Saves one cycle on dependent chains. Issue-cycle bypass into a free entry is unchanged.
- `RS_CDB_FORWARD_EN` undefined: select considers registered readiness only, as described above.

## Test plan

- Reset, then issue ADDI (`v1`=5, `imm`=7, rob 3) at edge 0 → at edge 1: `alu_opcode`=ADDI, `alu_val1`=5, `alu_imm`=7, `alu_rob_index`=3. At edge 2: `alu_opcode`=0.
- Issue ADD with `q1`=9 pending, then `alu_cdb` {rob 9, val 0x10} two cycles later.
  - Without the macro: dispatch one edge after the CDB edge, with `alu_val1`=0x10.
  - With `RS_CDB_FORWARD_EN`: dispatch on the CDB edge itself.
- Issue with `q2`=4 while `lsb_cdb` {rob 4, val 0xAB} is broadcast in the same cycle → entry stored ready; dispatch at the next edge with `alu_val2`=0xAB.
- Fill all 16 entries with operands blocked on tag 7:
  - `rs_full`=1, and a 17th `issue_valid` is ignored.
  - Broadcast tag 7 → 16 consecutive dispatches in entry order 0..15, then `rs_full`=0.
- Hold 5 entries, assert `flush_in` together with `issue_valid` → next cycle all entries are free, `alu_opcode`=0 and the issued instruction is not stored.
- Drop `rdy_in` for 3 cycles with a ready entry and a CDB pulse → outputs and state unchanged. The dispatch occurs on the first edge after `rdy_in` returns high.
